posit32_encode_regime: RTL

Pipelined posit32 encoder (es=2). It is the inverse of the regime-count/decode path: it takes a decoded value (sign, regime k, exponent, fraction, sticky) and packs it into a 32-bit posit word. It builds the regime run, concatenates exponent and fraction, rounds to nearest even, saturates and negates. It sits at the tail of posit arithmetic units, ahead of the register writeback. Valid/ready handshake on both sides.

---
 rtl/posit32_encode_regime.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/posit32_encode_regime.sv
// rtl/posit32_encode_regime.sv - two-stage posit32 (es=2) encoder: regime build, RNE rounding, saturation, sign
module posit32_encode_regime #(
   parameter int FRAC_W = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic              in_zero,
   input  logic              in_nar,
   input  logic [6:0]        in_k,
   input  logic [1:0]        in_exp,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_sticky,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_posit
);

   localparam logic [63:0] TOP_ONE  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [30:0] MAXPOS   = 31'h7FFF_FFFF;

   logic        adv;

   logic        s1_valid_q, s1_valid_d;
   logic [30:0] s1_body_q, s1_body_d;
   logic        s1_guard_q, s1_guard_d;
   logic        s1_sticky_q, s1_sticky_d;
   logic        s1_sign_q, s1_sign_d;
   logic        s1_zero_q, s1_zero_d;
   logic        s1_nar_q, s1_nar_d;
   logic        s1_sat_max_q, s1_sat_max_d;
   logic        s1_sat_min_q, s1_sat_min_d;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_posit_q, out_posit_d;

   logic        k_neg;
   logic [6:0]  k_mag;
   logic [6:0]  reg_len;
   logic [63:0] regime64;
   logic [63:0] tail64;
   logic [63:0] stream;

   logic        round_up;
   logic [31:0] body_sum;
   logic [30:0] body_r;
   logic [31:0] mag;
   logic [31:0] word;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_posit = out_posit_q;

   // Stage 1: regime run placed at the top of a 64-bit stream, exp/frac appended right after it
   always_comb begin
      k_neg    = in_k[6];
      k_mag    = k_neg ? (~in_k + 7'd1) : in_k;
      reg_len  = k_neg ? (k_mag + 7'd1) : (k_mag + 7'd2);
      regime64 = k_neg ? (TOP_ONE >> k_mag) : ~(ALL_ONES >> (k_mag + 7'd1));
      tail64   = {in_exp, in_frac, {(62 - FRAC_W){1'b0}}};
      stream   = regime64 | (tail64 >> reg_len);

      s1_valid_d   = s1_valid_q;
      s1_body_d    = s1_body_q;
      s1_guard_d   = s1_guard_q;
      s1_sticky_d  = s1_sticky_q;
      s1_sign_d    = s1_sign_q;
      s1_zero_d    = s1_zero_q;
      s1_nar_d     = s1_nar_q;
      s1_sat_max_d = s1_sat_max_q;
      s1_sat_min_d = s1_sat_min_q;

      if (adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_body_d    = stream[63:33];
            s1_guard_d   = stream[32];
            s1_sticky_d  = (|stream[31:0]) | in_sticky;
            s1_sign_d    = in_sign;
            s1_zero_d    = in_zero;
            s1_nar_d     = in_nar;
            s1_sat_max_d = $signed(in_k) > 7'sd30;
            s1_sat_min_d = $signed(in_k) < -7'sd30;
         end
      end
   end

   // Stage 2: round to nearest even; a carry out of the body clamps to maxpos instead of reaching NaR
   always_comb begin
      round_up = s1_guard_q && (s1_sticky_q || s1_body_q[0]);
      body_sum = {1'b0, s1_body_q} + {31'd0, round_up};
      body_r   = body_sum[31] ? MAXPOS : body_sum[30:0];

      if (s1_sat_max_q)
         mag = {1'b0, MAXPOS};
      else if (s1_sat_min_q)
         mag = 32'h0000_0001;
      else
         mag = {1'b0, body_r};

      if (s1_nar_q)
         word = 32'h8000_0000;
      else if (s1_zero_q)
         word = 32'h0000_0000;
      else if (s1_sign_q)
         word = ~mag + 32'd1;
      else
         word = mag;

      out_valid_d = out_valid_q;
      out_posit_d = out_posit_q;
      if (adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q)
            out_posit_d = word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_body_q    <= '0;
         s1_guard_q   <= 1'b0;
         s1_sticky_q  <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_nar_q     <= 1'b0;
         s1_sat_max_q <= 1'b0;
         s1_sat_min_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_posit_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_body_q    <= s1_body_d;
         s1_guard_q   <= s1_guard_d;
         s1_sticky_q  <= s1_sticky_d;
         s1_sign_q    <= s1_sign_d;
         s1_zero_q    <= s1_zero_d;
         s1_nar_q     <= s1_nar_d;
         s1_sat_max_q <= s1_sat_max_d;
         s1_sat_min_q <= s1_sat_min_d;
         out_valid_q  <= out_valid_d;
         out_posit_q  <= out_posit_d;
      end
   end

   // Upstream must keep a refused beat pending until it is taken
   in_valid_held : assert property (@(posedge clk) disable iff (rst)
      (in_valid && !in_ready) |=> in_valid);

endmodule
